// File: rtl/restart_sequencer_pkg.sv
// rtl/restart_sequencer_pkg.sv - shared types and constants for the restart sequencer
// Holds the sequencer state encoding, the phase counter width and the default
// parameter values shared with the restart register front end.
package restart_sequencer_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_PULSE_WIDTH   = 128;
  localparam int DEF_HALT_TIMEOUT  = 4096;
  localparam int DEF_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // A phase lasting N cycles loads the down-counter with N-1 and ends on zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/restart_sequencer_if.sv
// rtl/restart_sequencer_if.sv - request/DMA/status bundle of the restart sequencer
// Ports (master = sequencer side):
//   req, halt_ack              : request sources and DMA quiesce acknowledge
//   halt, restartn, busy, done : sequencing controls and progress
//   cause, timed_out,
//   restart_count              : status towards the register block
interface restart_sequencer_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                     req;
  logic                                   halt_ack;
  logic                                   halt;
  logic                                   restartn;
  logic                                   busy;
  logic                                   done;
  logic [NUM_REQ-1:0]                     cause;
  logic                                   timed_out;
  logic [restart_sequencer_pkg::CNT_W-1:0] restart_count;

  modport master (
    input  req, halt_ack,
    output halt, restartn, busy, done, cause, timed_out, restart_count
  );

  modport slave (
    output req, halt_ack,
    input  halt, restartn, busy, done, cause, timed_out, restart_count
  );

endinterface

// File: rtl/restart_sequencer_timer.sv
// rtl/restart_sequencer_timer.sv - loadable 16-bit down-counter for the sequencer phases
// Ports:
//   clk, reset : clock, synchronous active-high reset (count <- RESET_VAL)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : count has reached zero; counting stops there
module restart_timer
  import restart_sequencer_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/restart_sequencer.sv
// rtl/restart_sequencer.sv - arbitrates restart requests and sequences halt/restart/settle
// Ports:
//   clk   : single clock
//   reset : synchronous active-high reset; starts a power-up restart
//   bus   : restart_sequencer_if master side (requests, DMA handshake, status)
module restart_sequencer
  import restart_sequencer_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int PULSE_WIDTH   = DEF_PULSE_WIDTH,
  parameter int HALT_TIMEOUT  = DEF_HALT_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  restart_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] cause_q, cause_d;
  logic               halt_q, halt_d;
  logic               restartn_q, restartn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic [NUM_REQ-1:0] req_all;

  restart_timer #(
    .RESET_VAL (cnt_load(PULSE_WIDTH))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    cause_d     = cause_q;
    halt_d      = halt_q;
    restartn_d  = restartn_q;
    done_d      = 1'b0;
    timed_out_d = timed_out_q;
    count_d     = count_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    req_all     = pending_q | bus.req;

    case (state_q)
      // DONE also makes the start decision, so back-to-back sequences leave
      // halt low only for the single DONE cycle.
      ST_IDLE, ST_DONE: begin
        state_d   = ST_IDLE;
        pending_d = req_all;
        if (|req_all) begin
          cause_d     = req_all;
          pending_d   = '0;
          timed_out_d = 1'b0;
          halt_d      = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = cnt_load(HALT_TIMEOUT);
          state_d     = ST_HALT;
        end
      end
      ST_HALT: begin
        // Requests during the halt wait are covered by this restart.
        cause_d = cause_q | bus.req;
        if (bus.halt_ack || tmr_zero) begin
          timed_out_d = !bus.halt_ack;
          restartn_d  = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = cnt_load(PULSE_WIDTH);
          state_d     = ST_PULSE;
        end
      end
      ST_PULSE: begin
        pending_d = req_all;
        if (tmr_zero) begin
          restartn_d = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = cnt_load(SETTLE_CYCLES);
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        pending_d = req_all;
        if (tmr_zero) begin
          done_d  = 1'b1;
          halt_d  = 1'b0;
          count_d = count_q + 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PULSE;
      pending_q   <= '0;
      cause_q     <= '0;
      halt_q      <= 1'b1;
      restartn_q  <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cause_q     <= cause_d;
      halt_q      <= halt_d;
      restartn_q  <= restartn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      count_q     <= count_d;
    end
  end

  assign bus.halt          = halt_q;
  assign bus.restartn      = restartn_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cause         = cause_q;
  assign bus.timed_out     = timed_out_q;
  assign bus.restart_count = count_q;

endmodule
